// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between an SPI command stream and a host port
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        spi_rx_data,
  input  logic              spi_rx_valid,
  output logic [7:0]        spi_tx_data,
  output logic              spi_tx_valid,
  output logic              spi_overrun,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
  localparam logic HOST = 1'b1;
  localparam int CW = $clog2(RD_LAT + 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] wr_addr, rd_addr, pend_addr, op_addr, pay_a;
  logic [DATA_W-1:0] pend_data, op_data, pay_d;
  logic [CW-1:0] cnt;
  logic [1:0] cmd;
  logic pend, pend_we, op_we, op_owner, last_owner;
  logic spi_acc, spi_win, host_win, rd_last;
  assign cmd = spi_rx_data[9:8];
  assign pay_a = ADDR_W'(spi_rx_data[7:0]);
  assign pay_d = DATA_W'(spi_rx_data[7:0]);
  assign spi_acc = spi_rx_valid && cmd[0];
  // on a tie the requester that did not own the last access wins
  assign spi_win = state == IDLE && pend && (!host_req || last_owner == HOST);
  assign host_win = state == IDLE && host_req && !spi_win;
  assign host_gnt = host_win && !rst;
  assign rd_last = state == RD_WAIT && cnt == CW'(RD_LAT);
  always_comb begin
    state_nx = state;
    ram_en = 1'b0;
    ram_we = 1'b0;
    ram_addr = '0;
    ram_wdata = '0;
    case (state)
      IDLE: state_nx = (spi_win || host_win) ? ISSUE : IDLE;
      ISSUE: begin
        state_nx = op_we ? IDLE : RD_WAIT;
        ram_en = 1'b1;
        ram_we = op_we;
        ram_addr = op_addr;
        ram_wdata = op_data;
      end
      RD_WAIT: state_nx = rd_last ? IDLE : RD_WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_owner <= HOST;
      wr_addr <= '0;
      rd_addr <= '0;
      pend <= 1'b0;
      pend_we <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      op_owner <= 1'b0;
      op_we <= 1'b0;
      op_addr <= '0;
      op_data <= '0;
      cnt <= '0;
      spi_tx_data <= '0;
      spi_tx_valid <= 1'b0;
      spi_overrun <= 1'b0;
      host_rdata <= '0;
      host_rvalid <= 1'b0;
    end else begin
      state <= state_nx;
      spi_tx_valid <= 1'b0;
      host_rvalid <= 1'b0;
      spi_overrun <= spi_acc && pend && !spi_win;
      cnt <= state == RD_WAIT ? cnt + CW'(1) : CW'(1);
      if (spi_rx_valid && cmd == 2'b00) wr_addr <= pay_a;
      if (spi_rx_valid && cmd == 2'b10) rd_addr <= pay_a;
      if (spi_win) pend <= 1'b0;
      // a slot being granted this cycle frees room for the incoming access
      if (spi_acc && (!pend || spi_win)) begin
        pend <= 1'b1;
        pend_we <= !cmd[1];
        pend_addr <= cmd[1] ? rd_addr : wr_addr;
        pend_data <= cmd[1] ? '0 : pay_d;
      end
      if (spi_win || host_win) begin
        last_owner <= host_win;
        op_owner <= host_win;
        op_we <= spi_win ? pend_we : host_we;
        op_addr <= spi_win ? pend_addr : host_addr;
        op_data <= spi_win ? pend_data : (host_we ? host_wdata : '0);
      end
      if (rd_last && op_owner == HOST) begin
        host_rdata <= ram_rdata;
        host_rvalid <= 1'b1;
      end
      if (rd_last && op_owner != HOST) begin
        spi_tx_data <= ram_rdata[7:0];
        spi_tx_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vectors, corner sequences and a randomized run against a transaction-level model
module tb_ram_port_arbiter;
  localparam int AW = 8, DW = 8, RL = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] spi_rx_data = '0;
  logic spi_rx_valid = 1'b0;
  logic [7:0] spi_tx_data;
  logic spi_tx_valid, spi_overrun;
  logic host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  int n_cmp = 0, n_bad = 0;
  logic mon_en = 1'b0;
  logic [7:0] spi_q[$], host_q[$];
  logic [7:0] shadow [256];

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid), .spi_overrun(spi_overrun),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // RAM with RL-cycle read latency
  logic [DW-1:0] mem [256] = '{default: '0};
  logic [DW-1:0] rpipe [1:RL] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    rpipe[1] <= mem[ram_addr];
    for (int i = 2; i <= RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[RL];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {spi_tx_data, spi_tx_valid, spi_overrun, host_gnt, host_rdata, host_rvalid,
             ram_en, ram_we, ram_addr, ram_wdata}, 64'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(input logic [9:0] w);
    spi_rx_data = w;
    spi_rx_valid = 1'b1;
    cyc();
    spi_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("rand_overrun", spi_overrun, 0);
    if (spi_tx_valid) begin
      chk("rand_spi_expected", spi_q.size() != 0, 1);
      if (spi_q.size() != 0) chk("rand_spi_rdata", spi_tx_data, spi_q.pop_front());
    end
    if (host_rvalid) begin
      chk("rand_host_expected", host_q.size() != 0, 1);
      if (host_q.size() != 0) chk("rand_host_rdata", host_rdata, host_q.pop_front());
    end
  end

  typedef struct {logic [7:0] wa, wd, ra, rd_exp;} vec_t;

  initial begin
    vec_t vt [5];
    vt[0] = '{8'h2A, 8'h55, 8'h2A, 8'h55};
    vt[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vt[2] = '{8'hFF, 8'h01, 8'hFF, 8'h01};
    vt[3] = '{8'h10, 8'h3C, 8'h2A, 8'h55};
    vt[4] = '{8'h80, 8'h00, 8'h80, 8'h00};

    repeat (2) cyc();
    chk_zero("reset_outputs");
    rst = 1'b0;
    cyc();

    foreach (vt[i]) begin
      rx({2'b00, vt[i].wa});
      rx({2'b01, vt[i].wd});
      cyc();
      chk("vec_wr_en_we", {ram_en, ram_we}, 2'b11);
      chk("vec_wr_addr", ram_addr, vt[i].wa);
      chk("vec_wr_data", ram_wdata, vt[i].wd);
      cyc();
      chk("vec_idle_bus", {ram_en, ram_we, ram_addr, ram_wdata}, 0);
      rx({2'b10, vt[i].ra});
      rx({2'b11, 8'h00});
      cyc();
      chk("vec_rd_en_we", {ram_en, ram_we}, 2'b10);
      chk("vec_rd_addr", ram_addr, vt[i].ra);
      repeat (RL) begin
        cyc();
        chk("vec_tx_early", spi_tx_valid, 0);
      end
      cyc();
      chk("vec_tx_valid", spi_tx_valid, 1);
      chk("vec_tx_data", spi_tx_data, vt[i].rd_exp);
      cyc();
      chk("vec_tx_pulse", spi_tx_valid, 0);
      chk("vec_tx_hold", spi_tx_data, vt[i].rd_exp);
    end

    // host write then read back
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hAA;
    #1 chk("host_wr_gnt", host_gnt, 1);
    cyc();
    host_req = 1'b0;
    #1 chk("host_gnt_pulse", host_gnt, 0);
    chk("host_wr_bus", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 8'h10, 8'hAA});
    cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; host_wdata = 8'h00;
    #1 chk("host_rd_gnt", host_gnt, 1);
    cyc();
    host_req = 1'b0;
    chk("host_rd_bus", {ram_en, ram_we, ram_addr}, {2'b10, 8'h10});
    repeat (RL) cyc();
    chk("host_rvalid_early", host_rvalid, 0);
    cyc();
    chk("host_rvalid", host_rvalid, 1);
    chk("host_rdata", host_rdata, 8'hAA);

    // tie after reset: SPI first, then alternation puts host ahead of the next SPI access
    do_reset();
    rx({2'b00, 8'h40});
    rx({2'b01, 8'h11});
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h50; host_wdata = 8'h77;
    spi_rx_data = {2'b01, 8'h22}; spi_rx_valid = 1'b1;
    #1 chk("tie1_host_waits", host_gnt, 0);
    cyc();
    spi_rx_valid = 1'b0;
    chk("tie1_spi_bus", {ram_en, ram_addr, ram_wdata}, {1'b1, 8'h40, 8'h11});
    chk("tie1_no_overrun", spi_overrun, 0);
    cyc();
    chk("tie2_host_wins", host_gnt, 1);
    cyc();
    host_req = 1'b0;
    chk("tie2_host_bus", {ram_en, ram_addr, ram_wdata}, {1'b1, 8'h50, 8'h77});
    repeat (2) cyc();
    chk("tie2_spi_bus", {ram_en, ram_addr, ram_wdata}, {1'b1, 8'h40, 8'h22});

    // overrun while a host read is in flight
    cyc();
    rx({2'b00, 8'h60});
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    #1 chk("ovr_host_gnt", host_gnt, 1);
    cyc();
    host_req = 1'b0;
    spi_rx_data = {2'b01, 8'h33}; spi_rx_valid = 1'b1;
    cyc();
    spi_rx_data = {2'b01, 8'h44};
    cyc();
    spi_rx_valid = 1'b0;
    chk("ovr_pulse", spi_overrun, 1);
    cyc();
    chk("ovr_pulse_end", spi_overrun, 0);
    chk("ovr_host_rvalid", {host_rvalid, host_rdata}, {1'b1, 8'hAA});
    cyc();
    chk("ovr_first_written", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 8'h60, 8'h33});
    repeat (4) begin
      cyc();
      chk("ovr_second_dropped", ram_en, 0);
    end
    chk("ovr_mem", mem[8'h60], 8'h33);

    // access arriving in the slot's grant cycle is kept
    rx({2'b01, 8'h5A});
    spi_rx_data = {2'b01, 8'h5B}; spi_rx_valid = 1'b1;
    cyc();
    spi_rx_valid = 1'b0;
    chk("gcap_first", {ram_en, ram_wdata}, {1'b1, 8'h5A});
    chk("gcap_no_overrun", spi_overrun, 0);
    repeat (2) cyc();
    chk("gcap_second", {ram_en, ram_addr, ram_wdata}, {1'b1, 8'h60, 8'h5B});

    // reset during RD_WAIT abandons the read
    cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h60;
    cyc();
    host_req = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk_zero("rst_in_rdwait");
    rst = 1'b0;
    repeat (5) begin
      cyc();
      chk("rst_no_rvalid", {host_rvalid, spi_tx_valid}, 0);
    end

    // randomized traffic: SPI uses 0x00-0x7F, host 0x80-0xFF
    foreach (shadow[i]) shadow[i] = mem[i];
    mon_en = 1'b1;
    fork
      begin
        logic [7:0] a, d;
        for (int n = 0; n < 40; n++) begin
          a = 8'($urandom_range(0, 127));
          d = 8'($urandom);
          if ($urandom_range(0, 1) == 1) begin
            rx({2'b00, a});
            shadow[a] = d;
            rx({2'b01, d});
          end else begin
            rx({2'b10, a});
            spi_q.push_back(shadow[a]);
            rx({2'b11, 8'h00});
          end
          repeat (12) cyc();
        end
      end
      begin
        logic [7:0] a, d;
        logic w;
        int k;
        for (int n = 0; n < 40; n++) begin
          a = 8'($urandom_range(128, 255));
          d = 8'($urandom);
          w = 1'($urandom_range(0, 1));
          host_req = 1'b1; host_we = w; host_addr = a; host_wdata = d;
          k = 0;
          #1;
          while (!host_gnt && k < 32) begin
            @(posedge clk);
            #2;
            k++;
          end
          chk("rand_host_gnt", host_gnt, 1);
          if (host_gnt) begin
            if (w) shadow[a] = d;
            else host_q.push_back(shadow[a]);
          end
          cyc();
          host_req = 1'b0;
          repeat ($urandom_range(0, 3)) cyc();
        end
      end
    join
    repeat (20) cyc();
    mon_en = 1'b0;
    chk("rand_spi_drained", spi_q.size(), 0);
    chk("rand_host_drained", host_q.size(), 0);
    foreach (shadow[i]) chk("rand_mem", mem[i], shadow[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
